// File: rtl/uproc_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : uproc_pkg                                                      |
// | Desc    : Shared opcode, register-select and sequencer state constants.  |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package uproc_pkg;

    localparam logic [3:0] OPCODE_NOP = 4'h0;
    localparam logic [3:0] OPCODE_ADD = 4'h1;
    localparam logic [3:0] OPCODE_SUB = 4'h2;
    localparam logic [3:0] OPCODE_AND = 4'h3;
    localparam logic [3:0] OPCODE_OR  = 4'h4;
    localparam logic [3:0] OPCODE_XOR = 4'h5;
    localparam logic [3:0] OPCODE_LD  = 4'h6;
    localparam logic [3:0] OPCODE_ST  = 4'h7;

    localparam logic [1:0] R0 = 2'd0;
    localparam logic [1:0] R1 = 2'd1;
    localparam logic [1:0] R2 = 2'd2;
    localparam logic [1:0] R3 = 2'd3;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_FETCH     = 3'd1;
    localparam logic [2:0] ST_ISSUE     = 3'd2;
    localparam logic [2:0] ST_WAIT_STEP = 3'd3;
    localparam logic [2:0] ST_HALT      = 3'd4;

    typedef enum logic [2:0] {
        IDLE      = ST_IDLE,
        FETCH     = ST_FETCH,
        ISSUE     = ST_ISSUE,
        WAIT_STEP = ST_WAIT_STEP,
        HALT      = ST_HALT
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/instr_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : instr_sequencer                                                |
// | Desc    : PC owner and fetch/issue controller for the program memory.    |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module instr_sequencer
    import uproc_pkg::*;
#(
    parameter int ADDR_W   = 5,
    parameter int INS_W    = 6,
    parameter int END_ADDR = 31,
    parameter int WRAP     = 0,
    parameter int NOP_HALT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              step_mode,
    input  logic              step,
    input  logic              halt_req,
    input  logic              stall,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [INS_W-1:0]  mem_ins,
    output logic              ins_valid,
    output logic [INS_W-3:0]  opcode,
    output logic [1:0]        reg_sel,
    output logic [ADDR_W-1:0] pc_out,
    output logic              halted,
    output logic [7:0]        issue_cnt
);

    localparam int                OP_W      = INS_W - 2;
    localparam logic [ADDR_W-1:0] C_END     = ADDR_W'(END_ADDR);
    localparam logic [7:0]        C_NOP_LIM = 8'(NOP_HALT);
    localparam logic [OP_W-1:0]   C_NOP_OP  = OP_W'(OPCODE_NOP);

    seq_state_t        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_pc_out;
    logic [OP_W-1:0]   r_opcode;
    logic [1:0]        r_reg_sel;
    logic [7:0]        r_nop_run;
    logic [7:0]        r_issue_cnt;

    logic [7:0]        w_nop_next;
    logic              w_nop_hit;

    // NOP run value as it will be once the current issue is accepted
    always_comb begin
        w_nop_next = 8'd0;
        if (r_opcode == C_NOP_OP) begin
            w_nop_next = (r_nop_run >= C_NOP_LIM) ? r_nop_run : r_nop_run + 8'd1;
        end
        w_nop_hit = (NOP_HALT > 0) && (w_nop_next >= C_NOP_LIM);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_pc        <= '0;
            r_pc_out    <= '0;
            r_opcode    <= C_NOP_OP;
            r_reg_sel   <= R0;
            r_nop_run   <= 8'd0;
            r_issue_cnt <= 8'd0;
        end else begin
            case (r_state)
                IDLE, HALT: begin
                    if (start) begin
                        r_state     <= FETCH;
                        r_pc        <= '0;
                        r_nop_run   <= 8'd0;
                        r_issue_cnt <= 8'd0;
                    end
                end
                FETCH: begin
                    {r_opcode, r_reg_sel} <= mem_ins;
                    r_pc_out              <= r_pc;
                    r_state               <= ISSUE;
                end
                ISSUE: begin
                    if (!stall) begin
                        if (r_issue_cnt != 8'hFF) begin
                            r_issue_cnt <= r_issue_cnt + 8'd1;
                        end
                        r_nop_run <= w_nop_next;
                        if (halt_req || w_nop_hit) begin
                            r_state <= HALT;
                        end else if ((r_pc_out == C_END) && (WRAP == 0)) begin
                            r_state <= HALT;
                        end else begin
                            r_pc    <= (r_pc_out == C_END) ? '0 : r_pc_out + ADDR_W'(1);
                            r_state <= step_mode ? WAIT_STEP : FETCH;
                        end
                    end
                end
                WAIT_STEP: begin
                    if (halt_req) begin
                        r_state <= HALT;
                    end else if (step) begin
                        r_state <= FETCH;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mem_addr  = r_pc;
    assign ins_valid = (r_state == ISSUE);
    assign halted    = (r_state == HALT);
    assign opcode    = r_opcode;
    assign reg_sel   = r_reg_sel;
    assign pc_out    = r_pc_out;
    assign issue_cnt = r_issue_cnt;

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_instr_sequencer                                             |
// | Desc    : Scoreboard bench for instr_sequencer in three configurations.  |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_instr_sequencer;
    import uproc_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start     [3];
    logic       step_mode [3];
    logic       step      [3];
    logic       halt_req  [3];
    logic       stall     [3];
    logic [4:0] mem_addr  [3];
    logic [5:0] mem_ins   [3];
    logic       ins_valid [3];
    logic [3:0] opcode    [3];
    logic [1:0] reg_sel   [3];
    logic [4:0] pc_out    [3];
    logic       halted    [3];
    logic [7:0] issue_cnt [3];
    logic [5:0] mem       [3][32];

    logic [12:0] exp_q [$];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign mem_ins[0] = mem[0][mem_addr[0]];
    assign mem_ins[1] = mem[1][mem_addr[1]];
    assign mem_ins[2] = mem[2][mem_addr[2]];

    // A: default build; B: short wrapping program; C: END_ADDR 16, no NOP halt
    instr_sequencer #(.ADDR_W(5), .INS_W(6), .END_ADDR(31), .WRAP(0), .NOP_HALT(2)) dut_a (
        .clk(clk), .rst(rst), .start(start[0]), .step_mode(step_mode[0]), .step(step[0]),
        .halt_req(halt_req[0]), .stall(stall[0]), .mem_addr(mem_addr[0]), .mem_ins(mem_ins[0]),
        .ins_valid(ins_valid[0]), .opcode(opcode[0]), .reg_sel(reg_sel[0]), .pc_out(pc_out[0]),
        .halted(halted[0]), .issue_cnt(issue_cnt[0]));

    instr_sequencer #(.ADDR_W(5), .INS_W(6), .END_ADDR(3), .WRAP(1), .NOP_HALT(0)) dut_b (
        .clk(clk), .rst(rst), .start(start[1]), .step_mode(step_mode[1]), .step(step[1]),
        .halt_req(halt_req[1]), .stall(stall[1]), .mem_addr(mem_addr[1]), .mem_ins(mem_ins[1]),
        .ins_valid(ins_valid[1]), .opcode(opcode[1]), .reg_sel(reg_sel[1]), .pc_out(pc_out[1]),
        .halted(halted[1]), .issue_cnt(issue_cnt[1]));

    instr_sequencer #(.ADDR_W(5), .INS_W(6), .END_ADDR(16), .WRAP(0), .NOP_HALT(0)) dut_c (
        .clk(clk), .rst(rst), .start(start[2]), .step_mode(step_mode[2]), .step(step[2]),
        .halt_req(halt_req[2]), .stall(stall[2]), .mem_addr(mem_addr[2]), .mem_ins(mem_ins[2]),
        .ins_valid(ins_valid[2]), .opcode(opcode[2]), .reg_sel(reg_sel[2]), .pc_out(pc_out[2]),
        .halted(halted[2]), .issue_cnt(issue_cnt[2]));

    // Monitor: every accepted issue is matched against the next expected entry
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst && ins_valid[k] && !stall[k]) begin
                logic [12:0] got;
                logic [12:0] exp;
                got = {2'(k), pc_out[k], opcode[k], reg_sel[k]};
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL issue: unexpected dut=%0d pc=%0d op=%0h reg=%0d, none required",
                             k, pc_out[k], opcode[k], reg_sel[k]);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        fails++;
                        $display("FAIL issue: got dut=%0d pc=%0d ins=%02h, required dut=%0d pc=%0d ins=%02h",
                                 got[12:11], got[10:6], got[5:0], exp[12:11], exp[10:6], exp[5:0]);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input int k, input int pc);
        exp_q.push_back({2'(k), 5'(pc), mem[k][pc]});
    endtask

    task automatic pulse_start(input int k);
        start[k] = 1'b1;
        tick(1);
        start[k] = 1'b0;
    endtask

    task automatic wait_halt(input int k, input int budget);
        int n = 0;
        while (!halted[k] && n < budget) begin
            tick(1);
            n++;
        end
        check("halt_reached", 32'(halted[k]), 1);
    endtask

    task automatic check_reset(input int k);
        check("rst_mem_addr",  32'(mem_addr[k]),  0);
        check("rst_ins_valid", 32'(ins_valid[k]), 0);
        check("rst_opcode",    32'(opcode[k]),    32'(OPCODE_NOP));
        check("rst_reg_sel",   32'(reg_sel[k]),   0);
        check("rst_pc_out",    32'(pc_out[k]),    0);
        check("rst_halted",    32'(halted[k]),    0);
        check("rst_issue_cnt", 32'(issue_cnt[k]), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int n;
        int bad;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            start[k] = 1'b0; step_mode[k] = 1'b0; step[k] = 1'b0;
            halt_req[k] = 1'b0; stall[k] = 1'b0;
        end
        for (int a = 0; a < 32; a++) begin
            mem[0][a] = {OPCODE_NOP, R0};
            mem[1][a] = {OPCODE_LD, 2'(a)};
            mem[2][a] = (a == 4 || a == 5) ? {OPCODE_NOP, R0} : {OPCODE_SUB, 2'(a)};
        end
        mem[0][0] = {OPCODE_ADD, R1};
        mem[0][1] = {OPCODE_SUB, R1};
        tick(2);
        rst = 1'b0;
        check_reset(0);
        check_reset(1);

        // Free run until two consecutive NOPs halt the program
        for (int p = 0; p < 4; p++) push_exp(0, p);
        pulse_start(0);
        wait_halt(0, 40);
        check("t1_pc_out", 32'(pc_out[0]), 3);
        check("t1_issue_cnt", 32'(issue_cnt[0]), 4);
        check("t1_pc_frozen", 32'(mem_addr[0]), 3);

        // Stall holds the first issue for three extra cycles
        for (int p = 0; p < 4; p++) push_exp(0, p);
        stall[0] = 1'b1;
        pulse_start(0);
        tick(1);
        for (int i = 0; i < 3; i++) begin
            check("t2_valid_held", 32'(ins_valid[0]), 1);
            check("t2_opcode_held", 32'(opcode[0]), 32'(OPCODE_ADD));
            check("t2_pc_held", 32'(pc_out[0]), 0);
            tick(1);
        end
        check("t2_valid_4th", 32'(ins_valid[0]), 1);
        stall[0] = 1'b0;
        tick(1);
        check("t2_issue_cnt", 32'(issue_cnt[0]), 1);
        check("t2_pc", 32'(mem_addr[0]), 1);
        check("t2_valid_drop", 32'(ins_valid[0]), 0);
        wait_halt(0, 40);
        check("t2_issue_cnt_end", 32'(issue_cnt[0]), 4);

        // Single step: one issue per step pulse, nothing in between
        for (int p = 0; p < 4; p++) push_exp(0, p);
        step_mode[0] = 1'b1;
        pulse_start(0);
        cnt = 0;
        repeat (4) begin tick(1); cnt += int'(ins_valid[0]); end
        check("t3_first_issue", cnt, 1);
        for (int s = 0; s < 3; s++) begin
            step[0] = 1'b1;
            tick(1);
            step[0] = 1'b0;
            cnt = 0;
            repeat (4) begin tick(1); cnt += int'(ins_valid[0]); end
            check("t3_one_per_step", cnt, 1);
        end
        check("t3_halted", 32'(halted[0]), 1);
        step[0] = 1'b1;
        tick(1);
        step[0] = 1'b0;
        check("t3_step_ignored", 32'(ins_valid[0]), 0);
        step_mode[0] = 1'b0;

        // halt_req during a stalled issue at pc 5: the issue completes first
        for (int a = 2; a < 32; a++) mem[0][a] = {OPCODE_OR, 2'(a)};
        for (int p = 0; p < 6; p++) push_exp(0, p);
        pulse_start(0);
        n = 0;
        while (!(mem_addr[0] == 5'd5 && !ins_valid[0]) && n < 40) begin tick(1); n++; end
        check("t6_reach_pc5", 32'(mem_addr[0]), 5);
        stall[0] = 1'b1;
        tick(1);
        halt_req[0] = 1'b1;
        tick(2);
        check("t6_still_valid", 32'(ins_valid[0]), 1);
        check("t6_not_halted", 32'(halted[0]), 0);
        check("t6_pc_out", 32'(pc_out[0]), 5);
        stall[0] = 1'b0;
        tick(1);
        check("t6_halted", 32'(halted[0]), 1);
        check("t6_issue_cnt", 32'(issue_cnt[0]), 6);
        tick(3);
        check("t6_pc_frozen", 32'(mem_addr[0]), 5);
        halt_req[0] = 1'b0;

        // Wrapping program on B never halts by itself
        for (int i = 0; i < 7; i++) push_exp(1, i % 4);
        pulse_start(1);
        n = 0;
        bad = 0;
        while (issue_cnt[1] < 8'd6 && n < 60) begin
            tick(1);
            bad += int'(halted[1]);
            n++;
        end
        check("t4_no_halt", bad, 0);
        check("t4_issue_cnt", 32'(issue_cnt[1]), 6);
        halt_req[1] = 1'b1;
        wait_halt(1, 10);
        check("t4_final_pc", 32'(pc_out[1]), 2);
        check("t4_final_cnt", 32'(issue_cnt[1]), 7);
        halt_req[1] = 1'b0;

        // End-address halt on C, then restart from pc 0
        for (int p = 0; p <= 16; p++) push_exp(2, p);
        pulse_start(2);
        wait_halt(2, 100);
        check("t5_pc_out", 32'(pc_out[2]), 16);
        check("t5_issue_cnt", 32'(issue_cnt[2]), 17);
        check("t5_pc_frozen", 32'(mem_addr[2]), 16);
        push_exp(2, 0);
        halt_req[2] = 1'b1;
        pulse_start(2);
        tick(1);
        check("t5_restart_valid", 32'(ins_valid[2]), 1);
        check("t5_restart_pc", 32'(pc_out[2]), 0);
        check("t5_restart_cnt", 32'(issue_cnt[2]), 0);
        wait_halt(2, 10);
        check("t5_restart_cnt_end", 32'(issue_cnt[2]), 1);
        halt_req[2] = 1'b0;

        // Reset in the middle of a run
        push_exp(0, 0);
        push_exp(0, 1);
        pulse_start(0);
        n = 0;
        while (!(ins_valid[0] && pc_out[0] == 5'd2) && n < 40) begin tick(1); n++; end
        check("t6r_reach_pc2", 32'(pc_out[0]), 2);
        rst = 1'b1;
        tick(1);
        check_reset(0);
        rst = 1'b0;
        tick(2);
        check("t6r_idle_valid", 32'(ins_valid[0]), 0);
        check("t6r_idle_pc", 32'(mem_addr[0]), 0);

        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
